// File: rtl/pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_pkg
// Description : Shared pattern-buffer geometry and loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_pkg;
    localparam int BUFFER_SIZE  = 22;
    localparam int BUFFER_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage
`default_nettype wire

// File: rtl/pattern_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : pattern_loader_if
// Description : Host stream, scan-chain and status bundle of the pattern loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface pattern_loader_if #(
    parameter int BUFFER_SIZE  = pattern_pkg::BUFFER_SIZE,
    parameter int BUFFER_WIDTH = pattern_pkg::BUFFER_WIDTH
);
    logic                            start;
    logic                            abort;
    logic                            load_valid;
    logic [BUFFER_WIDTH-1:0]         load_data;
    logic                            load_ready;
    logic                            ssel;
    logic                            sin;
    logic                            sout;
    logic                            rd_valid;
    logic [BUFFER_WIDTH-1:0]         rd_data;
    logic [$clog2(BUFFER_SIZE)-1:0]  rd_index;
    logic                            pat_hold;
    logic                            busy;
    logic                            done;

    modport master (
        output start, abort, load_valid, load_data, sout,
        input  load_ready, ssel, sin, rd_valid, rd_data, rd_index, pat_hold, busy, done
    );

    modport slave (
        input  start, abort, load_valid, load_data, sout,
        output load_ready, ssel, sin, rd_valid, rd_data, rd_index, pat_hold, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/pattern_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : pattern_shift_unit
// Description : Byte serialiser (MSB first) and sout capture with bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_shift_unit #(
    parameter int BUFFER_WIDTH = pattern_pkg::BUFFER_WIDTH
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    i_load,
    input  wire logic [BUFFER_WIDTH-1:0] i_load_data,
    input  wire logic                    i_shift,
    input  wire logic                    i_clear,
    input  wire logic                    i_sout,
    output logic                         o_sin,
    output logic [BUFFER_WIDTH-1:0]      o_cap,
    output logic                         o_last
);
    localparam int BIT_W = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;
    localparam logic [BIT_W-1:0] c_LAST_BIT = BIT_W'(BUFFER_WIDTH - 1);

    logic [BUFFER_WIDTH-1:0] r_piso;
    logic [BUFFER_WIDTH-1:0] r_cap;
    logic [BIT_W-1:0]        r_bit_cnt;
    logic                    w_last;

    assign w_last = (r_bit_cnt == c_LAST_BIT);

    // A load on the last bit overrides the shift so the next byte follows without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_piso    <= '0;
            r_cap     <= '0;
            r_bit_cnt <= '0;
        end else if (i_clear) begin
            r_piso    <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (i_shift) begin
                r_cap <= {r_cap[BUFFER_WIDTH-2:0], i_sout};
            end
            if (i_load) begin
                r_piso    <= i_load_data;
                r_bit_cnt <= '0;
            end else if (i_shift) begin
                r_piso    <= {r_piso[BUFFER_WIDTH-2:0], 1'b0};
                r_bit_cnt <= w_last ? '0 : r_bit_cnt + BIT_W'(1);
            end
        end
    end

    assign o_sin  = r_piso[BUFFER_WIDTH-1];
    assign o_cap  = r_cap;
    assign o_last = w_last;
endmodule
`default_nettype wire

// File: rtl/pattern_loader.sv
`default_nettype none
// ============================================================================
// Module      : pattern_loader
// Description : Streams host bytes into the pattern-buffer scan chain while
//               returning the previous contents as readback bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_loader #(
    parameter int BUFFER_SIZE  = pattern_pkg::BUFFER_SIZE,
    parameter int BUFFER_WIDTH = pattern_pkg::BUFFER_WIDTH
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    pattern_loader_if.slave bus
);
    import pattern_pkg::*;

    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
    localparam int IDX_W = $clog2(BUFFER_SIZE);
    localparam logic [CNT_W-1:0] c_LAST_BYTE = CNT_W'(BUFFER_SIZE - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = CNT_W'(BUFFER_SIZE);
    localparam logic [IDX_W-1:0] c_TOP_INDEX = IDX_W'(BUFFER_SIZE - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_byte_cnt;
    logic                    r_ssel;
    logic                    r_rd_valid;
    logic [IDX_W-1:0]        r_rd_index;

    logic                    w_load_ready;
    logic                    w_busy;
    logic                    w_done;
    logic                    w_hs;
    logic                    w_last;
    logic                    w_final;
    logic                    w_byte_end;
    logic                    w_start_acc;
    logic                    w_sin;
    logic [BUFFER_WIDTH-1:0] w_cap;

    assign w_hs        = bus.load_valid & w_load_ready;
    assign w_final     = (r_byte_cnt == c_LAST_BYTE);
    assign w_byte_end  = (r_state == SHIFT) & w_last;
    assign w_start_acc = (r_state == IDLE) & bus.start & ~bus.abort;

    pattern_shift_unit #(
        .BUFFER_WIDTH (BUFFER_WIDTH)
    ) u_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_hs),
        .i_load_data (bus.load_data),
        .i_shift     (r_state == SHIFT),
        .i_clear     (bus.abort),
        .i_sout      (bus.sout),
        .o_sin       (w_sin),
        .o_cap       (w_cap),
        .o_last      (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.abort) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (bus.start) w_state_next = WAIT;
                WAIT:    if (w_hs) w_state_next = SHIFT;
                SHIFT: begin
                    if (w_last) begin
                        if (w_final)   w_state_next = DONE;
                        else if (w_hs) w_state_next = SHIFT;
                        else           w_state_next = WAIT;
                    end
                end
                DONE:    w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Abort masks load_ready so a byte offered in the abort cycle is never consumed.
    always_comb begin
        w_load_ready = 1'b0;
        w_done       = 1'b0;
        w_busy       = (r_state != IDLE);
        case (r_state)
            WAIT:    w_load_ready = ~bus.abort;
            SHIFT:   w_load_ready = w_last & ~w_final & ~bus.abort;
            DONE:    w_done       = 1'b1;
            default: w_load_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ssel     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_index <= '0;
            r_byte_cnt <= '0;
        end else begin
            r_ssel     <= (w_state_next == SHIFT);
            r_rd_valid <= w_byte_end & ~bus.abort;
            if (w_byte_end) begin
                r_rd_index <= c_TOP_INDEX - IDX_W'(r_byte_cnt);
            end
            if (w_start_acc || bus.abort) begin
                r_byte_cnt <= '0;
            end else if (w_byte_end && (r_byte_cnt != c_CNT_MAX)) begin
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.load_ready = w_load_ready;
    assign bus.ssel       = r_ssel;
    assign bus.sin        = w_sin;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_data    = w_cap;
    assign bus.rd_index   = r_rd_index;
    assign bus.busy       = w_busy;
    assign bus.pat_hold   = w_busy;
    assign bus.done       = w_done;
endmodule
`default_nettype wire

// File: tb/tb_pattern_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_loader
// Description : Randomised bench with a scan-chain buffer model and readback scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_loader;
    localparam int BS = 22;
    localparam int BW = 8;
    localparam int NB = BS * BW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pattern_loader_if #(.BUFFER_SIZE(BS), .BUFFER_WIDTH(BW)) bus ();

    pattern_loader #(.BUFFER_SIZE(BS), .BUFFER_WIDTH(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Pattern buffer: first bit in ends at pattern[BS-1][BW-1], which drives sout.
    logic [NB-1:0] chain = '0;
    always @(posedge clk) if (bus.ssel) chain <= {chain[NB-2:0], bus.sin};
    assign bus.sout = chain[NB-1];

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int total = 0;
    int bad   = 0;
    logic [12:0] exp_q[$];
    int n_rd = 0, n_done = 0, n_ssel = 0;
    int first_ssel = -1, last_ssel = -1, done_edge = -1, pass_s = -1;
    bit mon_en = 1'b0;
    logic [7:0] first_rd_data, last_rd_data;
    logic [4:0] first_rd_idx, last_rd_idx;
    logic [7:0] pat [BS];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
                     name, act, act, exp, exp, edge_n);
        end
    endtask

    initial forever begin
        logic [12:0] e;
        @(posedge clk);
        #1;
        if (mon_en && rst_n) begin
            chk("pat_hold_eq_busy", bus.pat_hold, bus.busy);
            if (bus.ssel) begin
                n_ssel++;
                if (first_ssel < 0) first_ssel = edge_n;
                last_ssel = edge_n;
                chk("ssel_implies_busy", bus.busy, 1);
            end
            if (edge_n == pass_s) begin
                chk("wait_busy", bus.busy, 1);
                chk("wait_ready", bus.load_ready, 1);
                chk("wait_ssel", bus.ssel, 0);
            end
            if (done_edge >= 0 && edge_n == done_edge + 1) chk("busy_after_done", bus.busy, 0);
            if (bus.rd_valid) begin
                if (n_rd == 0) begin
                    first_rd_data = bus.rd_data;
                    first_rd_idx  = bus.rd_index;
                end
                last_rd_data = bus.rd_data;
                last_rd_idx  = bus.rd_index;
                n_rd++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rd_extra: got rd_valid pulse %0d expected none", n_rd);
                end else begin
                    total--;
                    e = exp_q.pop_front();
                    chk("rd_data", bus.rd_data, e[7:0]);
                    chk("rd_index", bus.rd_index, e[12:8]);
                end
            end
            if (bus.done) begin
                n_done++;
                done_edge = edge_n;
                chk("done_with_rd_valid", bus.rd_valid, 1);
                chk("done_after_all_rd", exp_q.size(), 0);
            end
        end
    end

    // mode 0: back-to-back, 1: 5-cycle host gap after 4 bytes, 2: random load_valid
    task automatic run_pass(input logic [7:0] d [BS], input int mode, input int abort_at,
                            input int restart_at, input int exp_rd_abort);
        bit hs;
        bit aborted;
        int i;
        int t;
        int w;
        exp_q.delete();
        for (int k = BS - 1; k >= 0; k--) exp_q.push_back({5'(k), chain[k*BW +: BW]});
        n_rd = 0; n_done = 0; n_ssel = 0;
        first_ssel = -1; last_ssel = -1; done_edge = -1;
        @(negedge clk);
        bus.start = 1'b1;
        pass_s = edge_n + 1;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.load_data  = d[BS-1];
        bus.load_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        i = 0; t = 0; aborted = 1'b0;
        while (i < BS && t < 4000 && !aborted) begin
            if (abort_at >= 0 && edge_n == pass_s + abort_at) begin
                bus.abort = 1'b1;
                aborted   = 1'b1;
            end
            if (restart_at >= 0 && edge_n == pass_s + restart_at) bus.start = 1'b1;
            #1;
            hs = bus.load_valid && bus.load_ready;
            @(negedge clk);
            t++;
            bus.abort = 1'b0;
            bus.start = 1'b0;
            if (hs) begin
                i++;
                if (i < BS) bus.load_data = d[BS-1-i];
                if (mode == 1 && i == 4) begin
                    bus.load_valid = 1'b0;
                    w = 0;
                    while (bus.ssel && w < 40) begin
                        @(negedge clk);
                        w++;
                    end
                    repeat (4) @(negedge clk);
                    bus.load_valid = 1'b1;
                end
            end
            if (mode == 2) bus.load_valid = ($urandom_range(0, 3) != 0);
        end
        bus.load_valid = 1'b0;
        if (aborted) begin
            chk("abort_ssel", bus.ssel, 0);
            chk("abort_busy", bus.busy, 0);
            chk("abort_ready", bus.load_ready, 0);
            repeat (30) @(negedge clk);
            chk("abort_rd_count", n_rd, exp_rd_abort);
            chk("abort_done_count", n_done, 0);
            exp_q.delete();
        end else begin
            chk("host_bytes_accepted", i, BS);
            t = 0;
            while (n_done == 0 && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("done_seen", n_done, 1);
            repeat (3) @(negedge clk);
            chk("done_count", n_done, 1);
            chk("rd_count", n_rd, BS);
            chk("ssel_cycles", n_ssel, NB);
            for (int k = 0; k < BS; k++) chk("buf_contents", chain[k*BW +: BW], d[k]);
            if (mode == 0) begin
                chk("first_shift_cycle", first_ssel - pass_s + 1, 2);
                chk("done_cycle", done_edge - pass_s + 1, 178);
                chk("ssel_gap_cycles", last_ssel - first_ssel + 1 - n_ssel, 0);
            end
            if (mode == 1) chk("ssel_gap_cycles", last_ssel - first_ssel + 1 - n_ssel, 5);
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        repeat (3) @(negedge clk);
        chk("reset_ssel", bus.ssel, 0);
        chk("reset_sin", bus.sin, 0);
        chk("reset_ready", bus.load_ready, 0);
        chk("reset_rd_valid", bus.rd_valid, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_pat_hold", bus.pat_hold, 0);
        chk("reset_rd_index", bus.rd_index, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        for (int k = 0; k < BS; k++) pat[k] = 8'(k);
        run_pass(pat, 0, -1, -1, 0);
        chk("p1_buf21", chain[21*BW +: BW], 8'h15);
        chk("p1_buf0", chain[0 +: BW], 8'h00);
        chk("p1_first_rd", first_rd_data, 8'h00);

        for (int k = 0; k < BS; k++) pat[k] = 8'hFF;
        run_pass(pat, 0, -1, -1, 0);
        chk("p2_first_rd", first_rd_data, 8'h15);
        chk("p2_first_idx", first_rd_idx, 21);
        chk("p2_last_rd", last_rd_data, 8'h00);
        chk("p2_last_idx", last_rd_idx, 0);
        chk("p2_buf7", chain[7*BW +: BW], 8'hFF);

        for (int k = 0; k < BS; k++) pat[k] = 8'($urandom);
        run_pass(pat, 1, -1, -1, 0);

        for (int k = 0; k < BS; k++) pat[k] = 8'($urandom);
        run_pass(pat, 0, 27, -1, 3);

        for (int k = 0; k < BS; k++) pat[k] = 8'($urandom);
        run_pass(pat, 0, -1, 60, 0);

        mon_en = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hA5;
        repeat (12) @(negedge clk);
        chk("pre_reset_ssel", bus.ssel, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_ssel", bus.ssel, 0);
        chk("midreset_sin", bus.sin, 0);
        chk("midreset_busy", bus.busy, 0);
        chk("midreset_ready", bus.load_ready, 0);
        chk("midreset_rd_valid", bus.rd_valid, 0);
        chk("midreset_done", bus.done, 0);
        @(negedge clk);
        bus.load_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_busy", bus.busy, 0);
        chk("post_reset_ssel", bus.ssel, 0);
        mon_en = 1'b1;

        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < BS; k++) pat[k] = 8'($urandom);
            run_pass(pat, 2, -1, -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pattern_loader.md
# pattern_loader

Host-side serial engine for the pattern buffer's scan chain.
- Accepts pattern bytes from a host over a valid/ready stream and serialises them MSB-first onto the buffer's `sin` with `ssel` asserted.
- Captures the buffer's `sout` on every shift, returning the previous buffer contents as bytes, so one pass is a full write-and-readback.
- Sits between the host/configuration port and `patternbuf`, and stalls PAT while the chain is shifting.

## Interface
Parameters:
- `BUFFER_SIZE`, 22: bytes in the pattern buffer chain.
- `BUFFER_WIDTH`, 8: bits per byte.

Ports:
- `clk`  in  1  single clock, shared with the pattern buffer.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load pass; ignored unless idle.
- `abort`  in  1  terminate the pass; wins over all other inputs.
- `load_valid`  in  1  host byte available.
- `load_data`  in  BUFFER_WIDTH  host byte; highest buffer index first.
- `load_ready`  out  1  loader accepts `load_data` this cycle.
- `ssel`  out  1  buffer shift enable (registered).
- `sin`  out  1  serial data into the buffer (registered).
- `sout`  in  1  serial data from the buffer's last bit.
- `rd_valid`  out  1  one-cycle pulse, readback byte valid.
- `rd_data`  out  BUFFER_WIDTH  previous buffer contents, highest index first.
- `rd_index`  out  $clog2(BUFFER_SIZE)  buffer index of `rd_data`.
- `pat_hold`  out  1  stall PAT / block `field_write`; equals `busy`.
- `busy`  out  1  pass in progress.
- `done`  out  1  one-cycle pulse, pass complete.

## Operation
- **Reset values:** all outputs 0, state IDLE, counters 0.
- **Chain order:** first bit shifted in lands at `pattern[BUFFER_SIZE-1][BUFFER_WIDTH-1]`. Bytes are therefore sent index `BUFFER_SIZE-1` down to 0, each MSB first. This is `BUFFER_SIZE*BUFFER_WIDTH` shifts in total.
- **IDLE:** `start` moves to WAIT.
- **WAIT:** `load_ready`=1, `ssel`=0.
  - Handshake (`load_valid & load_ready`) loads the shift register and sets `ssel`=1, `sin`=`load_data[MSB]`. Then → SHIFT.
- **SHIFT:** `ssel`=1 for exactly `BUFFER_WIDTH` cycles; each edge advances `sin` to the next lower bit and samples `sout` into the capture register (LSB side).
  - `bit_cnt` runs 0..`BUFFER_WIDTH`-1.
  - On the last bit with bytes remaining, `load_ready`=1. If a handshake occurs, the next byte follows with no bubble (`ssel` stays 1). Otherwise → WAIT with `ssel`=0; the buffer holds and gaps are harmless.
  - After the final byte's last shift → DONE.
- **Readback:** after every `BUFFER_WIDTH` samples, `rd_valid`=1 for one cycle with the byte and `rd_index` = `BUFFER_SIZE-1`-`byte_cnt`. There is no backpressure.
- **DONE:** `done`=1 for one cycle, coincident with the final `rd_valid`, then → IDLE.
- **busy / pat_hold:** high from the cycle after `start` is accepted through the DONE cycle inclusive.
- **abort:** from any state, next cycle IDLE with `ssel`=0, `load_ready`=0, no `done` and no further `rd_valid`. Buffer contents are partially shifted.
- **Counters:**
  - `byte_cnt` is $clog2(`BUFFER_SIZE`+1) bits and saturates at `BUFFER_SIZE`; it never wraps.
  - `start` during a pass is ignored.

## Timing
- `start` sampled at edge S → `load_ready` high in cycle S+1.
- With `load_valid` held high:
  - first byte accepted at edge S+1;
  - buffer shifts at edges S+2 … S+1+`BUFFER_SIZE*BUFFER_WIDTH`;
  - `done` is high in the following cycle.
- Sampling `sout` at the same edge the buffer shifts captures the pre-shift bit. Readback is therefore exactly the old contents, with no offset bit.
- Reset mid-pass: outputs return to reset values immediately; `ssel` drops asynchronously.

## Structure
- `pattern_pkg` holds:
  - `BUFFER_SIZE` and `BUFFER_WIDTH` defaults, shared with `patternbuf`;
  - the state enum `{IDLE, WAIT, SHIFT, DONE}`.
- Sub-module `pattern_shift_unit` (~80 lines): parallel-in/serial-out plus serial-in/parallel-out registers and `bit_cnt`, with load/shift/last-bit outputs. The FSM, `byte_cnt` and handshakes stay in `pattern_loader`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-shift → `ssel`, `sin`, `busy`, `load_ready`, `rd_valid`, `done` all 0 immediately; FSM back to IDLE.
- **Full load:** defaults, buffer model zeroed; `start` then stream bytes 0x15…0x00 back-to-back → `ssel` high 176 consecutive cycles; afterwards `pattern[k]`=k for all k; `done` in cycle S+178.
- **Readback:** second pass with all bytes 0xFF → `rd_data` sequence 0x15, 0x14 … 0x00 with `rd_index` 21…0; buffer then all 0xFF.
- **Host gap:** drop `load_valid` for 5 cycles after byte 3 → `ssel`=0 exactly those cycles; final contents and readback identical to the gap-free pass.
- **Abort:** `abort` during byte 4 bit 2 → next cycle `ssel`=0, `busy`=0, no `done`, only 3 `rd_valid` pulses seen.
- **Ignored start:** `start` pulsed mid-pass → no effect on counts; exactly 22 `rd_valid` pulses and one `done`.
